// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit scheduler:
// state encoding, default sizes and byte width.
package uart_tx_pkg;

  localparam int BYTE_W      = 8;
  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 65535;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin pick: search starts one
// past the last grant and wraps around.
module uart_rr_arb
  import uart_tx_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx
);

  // first valid requester after last, one-hot plus index
  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(last) + k) % N_REQ;
      if (!found && valid[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one UART transmitter.
// Optional WAIT watchdog: UART_TXSCHED_TIMEOUT_EN.
module uart_tx_sched
  import uart_tx_pkg::*;
#(
  parameter  int N_REQ       = N_REQ_DEF,
  parameter  int TIMEOUT_CYC = TIMEOUT_DEF,
  localparam int IW          = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_start,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_done,
  output logic [IW-1:0]           tx_owner,
  output logic                    busy,
  output logic                    timeout_err
);

  state_t           state;
  state_t           state_nx;
  logic [IW-1:0]    last;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    idx;
  logic             any;
  logic             tmo_hit;

  uart_rr_arb #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .valid (req_valid),
    .last  (last),
    .gnt   (gnt),
    .idx   (idx)
  );

  assign any = |req_valid;

`ifdef UART_TXSCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;

  // WAIT cycle counter, cleared as WAIT is entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (state == S_LAUNCH) cnt <= '0;
    else if (state == S_WAIT)   cnt <= cnt + 1'b1;
  end

  assign tmo_hit = (state == S_WAIT) && !tx_done &&
                   (cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // next state and handshake outputs
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    tx_start  = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = gnt;
        if (any) state_nx = S_LAUNCH;
      end
      S_LAUNCH: begin
        tx_start = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done || tmo_hit) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // byte capture, owner tracking, pointer and abort pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last        <= IW'(N_REQ - 1);
      tx_data     <= '0;
      tx_owner    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_hit;
      if (state == S_IDLE && any) begin
        tx_data  <= req_data[idx*BYTE_W +: BYTE_W];
        tx_owner <= idx;
      end
      if (state == S_WAIT && (tx_done || tmo_hit))
        last <= tx_owner;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (N_REQ=4).
// Timeout path exercised when UART_TXSCHED_TIMEOUT_EN is set.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic [1:0]  tx_owner;
  logic        busy;
  logic        timeout_err;

  int n_run  = 0;
  int n_fail = 0;
  int nstart = 0;

  uart_tx_sched #(
    .N_REQ       (4),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .tx_owner    (tx_owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_start) nstart++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one full transfer for requester who with byte d
  task automatic xfer(input int who, input logic [7:0] d,
                      input bit drop);
    int s0;
    #1;
    chk("grant", 32'(req_ready), 32'(4'b1 << who));
    s0 = nstart;
    step();
    if (drop) req_valid[who] = 1'b0;
    #1;
    chk("launch_start", 32'(tx_start), 32'd1);
    chk("launch_data", 32'(tx_data), 32'(d));
    chk("launch_owner", 32'(tx_owner), 32'(who));
    chk("launch_ready", 32'(req_ready), 32'd0);
    step();
    chk("wait_start", 32'(tx_start), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("done_busy", 32'(busy), 32'd0);
    chk("one_start", 32'(nstart - s0), 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_owner", 32'(tx_owner), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    step();
    rst = 1'b1;
    step();

    // continuous four-way contention: 0,1,2,3,0
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    xfer(0, 8'h10, 1'b0);
    xfer(1, 8'h11, 1'b0);
    xfer(2, 8'h12, 1'b0);
    xfer(3, 8'h13, 1'b0);
    xfer(0, 8'h10, 1'b0);
    req_valid = '0;
    step();

    // single requester 2
    req_data  = 32'h00A50000;
    req_valid = 4'b0100;
    xfer(2, 8'hA5, 1'b1);

    // grant 3, then 0 and 3 -> 0 wins, then 3
    req_data  = 32'h3C00000C;
    req_valid = 4'b1000;
    xfer(3, 8'h3C, 1'b1);
    req_valid = 4'b1001;
    xfer(0, 8'h0C, 1'b1);
    xfer(3, 8'h3C, 1'b1);

    // spurious done in IDLE
    begin
      int s0;
      s0 = nstart;
      tx_done = 1'b1;
      #1;
      chk("idle_ready", 32'(req_ready), 32'd0);
      step();
      tx_done = 1'b0;
      chk("idle_busy", 32'(busy), 32'd0);
      step();
      chk("idle_nostart", 32'(nstart - s0), 32'd0);
    end

    // spurious done in LAUNCH
    req_data  = 32'h00007700;
    req_valid = 4'b0010;
    #1;
    chk("l_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    tx_done   = 1'b1;
    step();
    tx_done = 1'b0;
    chk("l_wait_busy", 32'(busy), 32'd1);
    step();
    step();
    chk("l_still_busy", 32'(busy), 32'd1);
    chk("l_no_restart", 32'(tx_start), 32'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("l_done_busy", 32'(busy), 32'd0);

    // async reset during WAIT of requester 1
    req_data  = 32'h0022BB00;
    req_valid = 4'b0010;
    #1;
    chk("r_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    step();
    chk("r_wait", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_data", 32'(tx_data), 32'd0);
    chk("ar_owner", 32'(tx_owner), 32'd0);
    chk("ar_start", 32'(tx_start), 32'd0);
    step();
    rst = 1'b1;
    req_valid = 4'b0110;
    xfer(1, 8'hBB, 1'b1);
    xfer(2, 8'h22, 1'b1);

    // WAIT with tx_done withheld
    req_data  = 32'h00005A66;
    req_valid = 4'b0001;
    #1;
    chk("t_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    step();
    for (int i = 0; i < 19; i++) step();
    chk("t_pre_err", 32'(timeout_err), 32'd0);
    chk("t_pre_busy", 32'(busy), 32'd1);
    step();
`ifdef UART_TXSCHED_TIMEOUT_EN
    chk("t_err", 32'(timeout_err), 32'd1);
    chk("t_idle", 32'(busy), 32'd0);
    step();
    chk("t_err_pulse", 32'(timeout_err), 32'd0);
    req_valid = 4'b0011;
    xfer(1, 8'h5A, 1'b1);
    req_valid = '0;
`else
    chk("t_no_err", 32'(timeout_err), 32'd0);
    chk("t_hold", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) step();
    chk("t_hold2", 32'(busy), 32'd1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("t_done", 32'(busy), 32'd0);
    req_valid = 4'b0011;
    xfer(1, 8'h5A, 1'b1);
    req_valid = '0;
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
